buslayer_slave: RTL and testbench

//  Wishbone B4 pipelined responder. It sits between the shared bus and one peripheral.
//  - Accepts one transfer at a time from buslayer_master.
//  - Decodes its address window and runs a req/ready handshake with the peripheral.
//  - Returns wb_ack or wb_err; holds wb_stall while a transfer is outstanding.

---
 rtl/buslayer_slave.sv | 176 +++++++++++++++++
 tb/tb_buslayer_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/buslayer_slave.sv
// buslayer_slave: Wishbone B4 pipelined responder for a single peripheral.
//
// It takes one bus transfer at a time and decodes it against its address window.
// On a hit it runs a req/ready handshake with the peripheral, then returns one
// wb_ack or wb_err pulse. wb_stall is high while a transfer is outstanding.
//
// Optional feature: define BUSLAYER_SLAVE_TIMEOUT_EN to abort an ACCESS with
// wb_err after TIMEOUT_CYCLES cycles without a peripheral response.
//
// Ports
//   wb_clk, wb_rst_n        bus clock (rising edge), asynchronous active-low reset
//   wb_cyc, wb_stb, wb_we   bus cycle, strobe, write enable
//   wb_sel, wb_adr          byte lanes, byte address
//   wb_dat_i / wb_dat_o     write data in / registered read data out
//   wb_ack, wb_err          one-cycle completion pulses
//   wb_stall                slave busy, new requests are not sampled
//   p_req                   peripheral request, held until p_ready | p_error
//   p_write, p_addr         latched write enable and word offset in the window
//   p_wdata, p_byte_sel     latched write data and byte lanes
//   p_rdata                 peripheral read data, valid with p_ready
//   p_ready, p_error        peripheral completion / failure
module buslayer_slave #(
    parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst_n,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [3:0]            wb_sel,
    input  logic [31:0]           wb_adr,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic                  wb_stall,
    output logic                  p_req,
    output logic                  p_write,
    output logic [ADDR_WIDTH-1:0] p_addr,
    output logic [31:0]           p_wdata,
    output logic [3:0]            p_byte_sel,
    input  logic [31:0]           p_rdata,
    input  logic                  p_ready,
    input  logic                  p_error
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    // Window size in bytes; 33 bits so the top of a window at 2**32 still fits.
    localparam logic [32:0] WinBytes = 33'd4 << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [31:0]           dat_q, dat_d;
    logic                  err_q, err_d;
    logic                  abort_q, abort_d;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  latch_en;
    logic                  timeout;
    logic                  p_done;
    logic [32:0]           offset;
    logic                  hit;

    // Below-base addresses borrow into bit 32 and so compare as out of range.
    assign offset = {1'b0, wb_adr} - {1'b0, BASE_ADDR};
    assign hit    = (offset < WinBytes);
    assign p_done = p_ready || p_error;

`ifdef BUSLAYER_SLAVE_TIMEOUT_EN
    logic [7:0] cnt_q;

    // Held at zero outside ACCESS, so it is clear on every ACCESS entry.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt_q <= 8'd0;
        end else if (state_q != StAccess) begin
            cnt_q <= 8'd0;
        end else if (!p_done) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign timeout = (state_q == StAccess) && !p_done &&
                     (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        dat_d    = dat_q;
        err_d    = err_q;
        abort_d  = abort_q;
        latch_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                dat_d = 32'd0;
                if (wb_cyc && wb_stb) begin
                    latch_en = 1'b1;
                    abort_d  = 1'b0;
                    if (hit && (wb_sel != 4'd0)) begin
                        err_d   = 1'b0;
                        state_d = StAccess;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StAccess: begin
                // A master abort only silences the response; the handshake finishes.
                if (!wb_cyc) begin
                    abort_d = 1'b1;
                end
                if (p_done) begin
                    err_d   = p_error;
                    dat_d   = we_q ? 32'd0 : p_rdata;
                    state_d = StResp;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    dat_d   = 32'd0;
                    state_d = StResp;
                end
            end
            StResp: begin
                dat_d   = 32'd0;
                state_d = StIdle;
            end
            default: begin
                dat_d   = 32'd0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= StIdle;
            dat_q   <= 32'd0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            if (latch_en) begin
                we_q    <= wb_we;
                sel_q   <= wb_sel;
                addr_q  <= offset[ADDR_WIDTH+1:2];
                wdata_q <= wb_dat_i;
            end
        end
    end

    assign wb_stall   = (state_q != StIdle);
    assign p_req      = (state_q == StAccess);
    assign wb_ack     = (state_q == StResp) && !err_q && !abort_q;
    assign wb_err     = (state_q == StResp) && err_q && !abort_q;
    assign wb_dat_o   = dat_q;
    assign p_write    = we_q;
    assign p_addr     = addr_q;
    assign p_wdata    = wdata_q;
    assign p_byte_sel = sel_q;

endmodule

// File: tb/tb_buslayer_slave.sv
// Directed bench for buslayer_slave. Stimulus pushes the expected response
// (ack, err, data, cycle of arrival) into a scoreboard queue; a monitor pops
// and compares whenever the slave drives wb_ack or wb_err.
module tb_buslayer_slave;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
    logic        wb_ack, wb_err, wb_stall;
    logic        p_req, p_write;
    logic [7:0]  p_addr;
    logic [31:0] p_wdata, p_rdata;
    logic [3:0]  p_byte_sel;
    logic        p_ready, p_error;

    buslayer_slave dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_sel    (wb_sel),
        .wb_adr    (wb_adr),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .wb_stall  (wb_stall),
        .p_req     (p_req),
        .p_write   (p_write),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_byte_sel(p_byte_sel),
        .p_rdata   (p_rdata),
        .p_ready   (p_ready),
        .p_error   (p_error)
    );

    always #5 wb_clk = ~wb_clk;

    int cyc_cnt = 0;
    always @(posedge wb_clk) cyc_cnt <= cyc_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge wb_clk) begin
        if (wb_rst_n && (wb_ack || wb_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {30'd0, wb_ack, wb_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_ack", {31'd0, wb_ack}, {31'd0, mon_e.ack});
                check("resp_err", {31'd0, wb_err}, {31'd0, mon_e.err});
                check("resp_dat", wb_dat_o, mon_e.dat);
                check("resp_cycle", cyc_cnt, mon_e.cyc);
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge wb_clk);
        #1;
    endtask

    task automatic push(input logic ack, input logic err, input logic [31:0] dat, input int cyc);
        exp_t e;
        e.ack = ack;
        e.err = err;
        e.dat = dat;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Presents one request in cycle n; returns in cycle n+1 with wb_stb low.
    task automatic issue(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output int n);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_adr   = adr;
        wb_we    = we;
        wb_dat_i = dat;
        wb_sel   = sel;
        n        = cyc_cnt;
        tick(1);
        wb_stb = 1'b0;
    endtask

    // Zero-wait write: p_ready in N+1, ack expected in N+2.
    task automatic fast_write(input logic [31:0] adr, input logic [31:0] dat,
                              input logic [7:0] exp_paddr);
        int n;
        issue(adr, 1'b1, dat, 4'hF, n);
        check("wr_preq", {31'd0, p_req}, 32'd1);
        check("wr_stall", {31'd0, wb_stall}, 32'd1);
        check("wr_paddr", {24'd0, p_addr}, {24'd0, exp_paddr});
        check("wr_pwdata", p_wdata, dat);
        check("wr_pwrite", {31'd0, p_write}, 32'd1);
        check("wr_psel", {28'd0, p_byte_sel}, 32'hF);
        p_ready = 1'b1;
        push(1'b1, 1'b0, 32'd0, n + 2);
        tick(1);
        p_ready = 1'b0;
        check("wr_preq_drop", {31'd0, p_req}, 32'd0);
        tick(1);
        wb_cyc = 1'b0;
        check("wr_idle", {31'd0, wb_stall}, 32'd0);
    endtask

    logic [31:0] dec_adr[3];
    logic [3:0]  dec_sel[3];

    initial begin
        int n;
        wb_rst_n = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 4'd0;
        wb_adr = 32'd0; wb_dat_i = 32'd0;
        p_rdata = 32'd0; p_ready = 1'b0; p_error = 1'b0;
        dec_adr[0] = 32'h4000_0400; dec_sel[0] = 4'hF;
        dec_adr[1] = 32'h4000_0020; dec_sel[1] = 4'h0;
        dec_adr[2] = 32'h3FFF_FFFC; dec_sel[2] = 4'hF;

        // Reset state
        tick(3);
        check("rst_stall", {31'd0, wb_stall}, 32'd0);
        check("rst_preq", {31'd0, p_req}, 32'd0);
        check("rst_ack_err", {30'd0, wb_ack, wb_err}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_platch", {p_addr, p_byte_sel, 19'd0, p_write}, 32'd0);
        check("rst_pwdata", p_wdata, 32'd0);
        wb_rst_n = 1'b1;
        tick(1);

        // Write hit, minimum latency
        fast_write(32'h4000_0010, 32'hDEAD_BEEF, 8'h04);

        // Read at top of window with three wait states
        issue(32'h4000_03FC, 1'b0, 32'd0, 4'hF, n);
        check("rd_paddr", {24'd0, p_addr}, 32'hFF);
        check("rd_pwrite", {31'd0, p_write}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            check("rd_stall_wait", {31'd0, wb_stall}, 32'd1);
            check("rd_preq_wait", {31'd0, p_req}, 32'd1);
            tick(1);
        end
        p_ready = 1'b1;
        p_rdata = 32'h1234_5678;
        push(1'b1, 1'b0, 32'h1234_5678, n + 5);
        check("rd_stall_n4", {31'd0, wb_stall}, 32'd1);
        tick(1);
        p_ready = 1'b0;
        p_rdata = 32'd0;
        check("rd_stall_n5", {31'd0, wb_stall}, 32'd1);
        tick(1);
        wb_cyc = 1'b0;
        check("rd_stall_n6", {31'd0, wb_stall}, 32'd0);
        check("rd_dat_cleared", wb_dat_o, 32'd0);

        // Decode errors: above window, sel == 0, below base
        for (int i = 0; i < 3; i++) begin
            issue(dec_adr[i], 1'b0, 32'd0, dec_sel[i], n);
            push(1'b0, 1'b1, 32'd0, n + 1);
            check("dec_preq", {31'd0, p_req}, 32'd0);
            check("dec_stall", {31'd0, wb_stall}, 32'd1);
            tick(1);
            wb_cyc = 1'b0;
            check("dec_preq_after", {31'd0, p_req}, 32'd0);
            check("dec_idle", {31'd0, wb_stall}, 32'd0);
        end

        // p_ready and p_error together: error wins
        issue(32'h4000_0008, 1'b1, 32'h0BAD_F00D, 4'h3, n);
        p_ready = 1'b1;
        p_error = 1'b1;
        push(1'b0, 1'b1, 32'd0, n + 2);
        tick(1);
        p_ready = 1'b0;
        p_error = 1'b0;
        tick(1);
        wb_cyc = 1'b0;

        // Master abort: handshake completes, RESP is silent
        issue(32'h4000_0044, 1'b0, 32'd0, 4'hF, n);
        wb_cyc = 1'b0;
        check("abort_preq", {31'd0, p_req}, 32'd1);
        tick(1);
        check("abort_preq_hold", {31'd0, p_req}, 32'd1);
        p_ready = 1'b1;
        p_rdata = 32'h5555_AAAA;
        tick(1);
        p_ready = 1'b0;
        check("abort_resp_stall", {31'd0, wb_stall}, 32'd1);
        check("abort_resp_silent", {30'd0, wb_ack, wb_err}, 32'd0);
        tick(1);
        check("abort_idle", {31'd0, wb_stall}, 32'd0);
        fast_write(32'h4000_0000, 32'h0000_0001, 8'h00);

`ifdef BUSLAYER_SLAVE_TIMEOUT_EN
        // Timeout: p_req held 16 cycles, then wb_err
        issue(32'h4000_0080, 1'b0, 32'd0, 4'hF, n);
        push(1'b0, 1'b1, 32'd0, n + 17);
        for (int i = 1; i <= 16; i++) begin
            check("to_preq", {31'd0, p_req}, 32'd1);
            tick(1);
        end
        check("to_preq_drop", {31'd0, p_req}, 32'd0);
        tick(1);
        wb_cyc = 1'b0;
        check("to_idle", {31'd0, wb_stall}, 32'd0);
`else
        // No timeout: still waiting after 100 cycles
        issue(32'h4000_0080, 1'b0, 32'd0, 4'hF, n);
        tick(100);
        check("wait_preq", {31'd0, p_req}, 32'd1);
        check("wait_stall", {31'd0, wb_stall}, 32'd1);
        p_ready = 1'b1;
        p_rdata = 32'hCAFE_F00D;
        push(1'b1, 1'b0, 32'hCAFE_F00D, n + 102);
        tick(1);
        p_ready = 1'b0;
        p_rdata = 32'd0;
        tick(1);
        wb_cyc = 1'b0;
`endif

        // Reset asserted mid-ACCESS
        issue(32'h4000_0100, 1'b0, 32'd0, 4'hF, n);
        tick(2);
        check("mid_preq_before", {31'd0, p_req}, 32'd1);
        wb_rst_n = 1'b0;
        #1;
        check("mid_rst_preq", {31'd0, p_req}, 32'd0);
        check("mid_rst_stall", {31'd0, wb_stall}, 32'd0);
        check("mid_rst_ack_err", {30'd0, wb_ack, wb_err}, 32'd0);
        check("mid_rst_paddr", {24'd0, p_addr}, 32'd0);
        tick(1);
        wb_cyc = 1'b0;
        wb_rst_n = 1'b1;
        tick(1);
        check("post_rst_idle", {31'd0, wb_stall}, 32'd0);
        fast_write(32'h4000_0004, 32'h7777_0000, 8'h01);

        tick(3);
        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
